updown_sweep_ctrl: RTL and testbench

Sequencer for the `up_down_counter` datapath: drives the counter's `rst` and `up_down` inputs so that `count` sweeps back and forth between programmable bounds `lo` and `hi` for a programmed number of sweeps, then parks the counter at 0. It sits beside the counter, watching `count` and steering direction turn-arounds combinationally so the counter never overshoots a bound. It is used for counter-driven scan and pattern generation.

---
 rtl/updown_pkg.sv | 12 +
 rtl/up_down_counter.sv | 23 ++
 rtl/updown_sweep_ctrl.sv | 130 +++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// Shared definitions for the up/down counter and its sweep controller.
package updown_pkg;

  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/up_down_counter.sv
// Free-running up/down counter with synchronous reset; wraps modulo 2^WIDTH.
module up_down_counter
  import updown_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (up_down) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count <= count - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Steers an up/down counter back and forth between captured bounds for a
// programmed number of sweeps, then parks it at 0 by holding its reset.
module updown_sweep_ctrl
  import updown_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int SW_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [SW_W-1:0]  n_sweeps,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             cnt_rst,
  output logic             cnt_up_down,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SW_W-1:0]  sweeps_done
);

  sweep_state_t     state_reg, state_next;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic [SW_W-1:0]  n_q;
  logic [SW_W-1:0]  sweeps_done_reg, sweeps_done_next;
  logic [SW_W-1:0]  sweeps_inc;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             capture;

  assign sweeps_inc  = sweeps_done_reg + {{(SW_W-1){1'b0}}, 1'b1};
  assign done        = done_reg;
  assign err         = err_reg;
  assign sweeps_done = sweeps_done_reg;

  always_comb begin
    state_next       = state_reg;
    sweeps_done_next = sweeps_done_reg;
    done_next        = 1'b0;
    err_next         = 1'b0;
    capture          = 1'b0;
    cnt_rst          = 1'b1;
    cnt_up_down      = 1'b1;
    busy             = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // abort beats a simultaneous start; the start is simply dropped
        if (start && !abort) begin
          if ((lo < hi) && (n_sweeps != '0)) begin
            capture          = 1'b1;
            sweeps_done_next = '0;
            state_next       = UP;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      UP: begin
        busy        = 1'b1;
        cnt_rst     = 1'b0;
        cnt_up_down = (cnt_in != hi_q);
        if (abort) begin
          state_next = IDLE;
        end else if (cnt_in == hi_q) begin
          state_next = DOWN;
        end
      end

      DOWN: begin
        busy    = 1'b1;
        cnt_rst = 1'b0;
        if (cnt_in == lo_q) begin
          // final turn-around resets the counter directly instead of reversing
          if (sweeps_inc == n_q) begin
            cnt_rst = 1'b1;
          end
          cnt_up_down = 1'b1;
          if (abort) begin
            state_next = IDLE;
          end else begin
            sweeps_done_next = sweeps_inc;
            if (sweeps_inc == n_q) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = UP;
            end
          end
        end else begin
          cnt_up_down = 1'b0;
          if (abort) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      lo_q            <= '0;
      hi_q            <= '0;
      n_q             <= '0;
      sweeps_done_reg <= '0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sweeps_done_reg <= sweeps_done_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
      if (capture) begin
        lo_q <= lo;
        hi_q <= hi;
        n_q  <= n_sweeps;
      end
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Drives the sweep controller with its counter in the loop; expected traces and
// done/err events are queued by the driver and checked by a monitor process.
module tb_updown_sweep_ctrl;
  import updown_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] lo, hi;
  logic [7:0] n_sweeps;
  logic [3:0] count;
  logic       cnt_rst, cnt_up_down, busy, done, err;
  logic [7:0] sweeps_done;

  typedef struct {
    logic [3:0] count;
    logic       busy;
    logic [7:0] sw;
  } trace_t;

  typedef struct {
    logic       is_done;
    logic [7:0] sw;
  } event_t;

  trace_t trace_q[$];
  event_t ev_q[$];
  int     vectors    = 0;
  int     miscompares = 0;

  always #5 clk = ~clk;

  updown_sweep_ctrl #(.WIDTH(4), .SW_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lo(lo), .hi(hi), .n_sweeps(n_sweeps), .cnt_in(count),
    .cnt_rst(cnt_rst), .cnt_up_down(cnt_up_down), .busy(busy),
    .done(done), .err(err), .sweeps_done(sweeps_done)
  );

  up_down_counter #(.WIDTH(4)) u_cnt (
    .clk(clk), .rst(cnt_rst), .up_down(cnt_up_down), .count(count)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_tr(input int c, input int b, input int s);
    trace_t t;
    t.count = 4'(c);
    t.busy  = 1'(b);
    t.sw    = 8'(s);
    trace_q.push_back(t);
  endtask

  task automatic push_ev(input bit is_done, input int s);
    event_t e;
    e.is_done = is_done;
    e.sw      = 8'(s);
    ev_q.push_back(e);
  endtask

  // Expected per-cycle trace of a full run, from the accepting edge onwards.
  task automatic push_run(input int l, input int h, input int n);
    int c = 0;
    int s = 0;
    push_tr(0, 1, 0);
    while (c < h) begin c++; push_tr(c, 1, s); end
    while (1) begin
      while (c > l) begin c--; push_tr(c, 1, s); end
      s++;
      if (s == n) begin
        push_tr(0, 0, s);
        break;
      end
      while (c < h) begin c++; push_tr(c, 1, s); end
    end
  endtask

  task automatic pulse_start(input int l, input int h, input int n);
    lo = 4'(l); hi = 4'(h); n_sweeps = 8'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for the monitor to consume all expectations, bounded.
  task automatic drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (trace_q.size() == 0 && ev_q.size() == 0) break;
      @(negedge clk);
    end
    if (trace_q.size() != 0 || ev_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d trace and %0d events left, expected 0",
               name, trace_q.size(), ev_q.size());
      trace_q.delete();
      ev_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: samples just after each rising edge.
  initial begin
    trace_t t;
    event_t e;
    forever begin
      @(posedge clk);
      #1;
      if (trace_q.size() > 0) begin
        t = trace_q.pop_front();
        chk("trace_count", int'(count), int'(t.count));
        chk("trace_busy", int'(busy), int'(t.busy));
        chk("trace_sweeps", int'(sweeps_done), int'(t.sw));
      end
      if (done || err) begin
        if (ev_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: done=%0d err=%0d, expected none", done, err);
        end else begin
          e = ev_q.pop_front();
          chk("event_done", int'(done), int'(e.is_done));
          chk("event_err", int'(err), int'(!e.is_done));
          chk("event_sweeps", int'(sweeps_done), int'(e.sw));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    lo = '0; hi = '0; n_sweeps = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_cnt_rst", int'(cnt_rst), 1);
    chk("rst_cnt_up_down", int'(cnt_up_down), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_sweeps", int'(sweeps_done), 0);
    chk("rst_count", int'(count), 0);

    // single sweep, hand-written trace 0,1,2,3,4,5,4,3,2,0
    push_tr(0, 1, 0); push_tr(1, 1, 0); push_tr(2, 1, 0); push_tr(3, 1, 0);
    push_tr(4, 1, 0); push_tr(5, 1, 0); push_tr(4, 1, 0); push_tr(3, 1, 0);
    push_tr(2, 1, 0); push_tr(0, 0, 1);
    push_ev(1'b1, 1);
    pulse_start(2, 5, 1);
    drain("single");

    // rejected: lo == hi
    push_tr(0, 0, 1); push_tr(0, 0, 1); push_tr(0, 0, 1);
    push_ev(1'b0, 1);
    pulse_start(7, 7, 2);
    drain("reject_bounds");

    // rejected: zero sweeps
    push_tr(0, 0, 1); push_tr(0, 0, 1); push_tr(0, 0, 1);
    push_ev(1'b0, 1);
    pulse_start(1, 9, 0);
    drain("reject_n0");

    // abort together with start in IDLE drops the start
    push_tr(0, 0, 1); push_tr(0, 0, 1); push_tr(0, 0, 1);
    abort = 1'b1;
    pulse_start(1, 3, 1);
    abort = 1'b0;
    drain("abort_start_idle");

    // three full-range sweeps
    push_run(0, 15, 3);
    push_ev(1'b1, 3);
    pulse_start(0, 15, 3);
    drain("repeat");

    // start with new bounds while busy is ignored
    push_tr(0, 1, 0); push_tr(1, 1, 0); push_tr(2, 1, 0); push_tr(3, 1, 0);
    push_tr(4, 1, 0); push_tr(3, 1, 0); push_tr(2, 1, 0); push_tr(1, 1, 0);
    push_tr(0, 0, 1);
    push_ev(1'b1, 1);
    pulse_start(1, 4, 1);
    repeat (2) @(negedge clk);
    pulse_start(0, 9, 2);
    drain("start_busy");

    // abort on the down-leg at count 4
    push_tr(0, 1, 0); push_tr(1, 1, 0); push_tr(2, 1, 0); push_tr(3, 1, 0);
    push_tr(4, 1, 0); push_tr(5, 1, 0); push_tr(6, 1, 0); push_tr(5, 1, 0);
    push_tr(4, 1, 0); push_tr(3, 0, 0); push_tr(0, 0, 0); push_tr(0, 0, 0);
    pulse_start(1, 6, 2);
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain("abort_run");

    // reset mid-run
    push_tr(0, 1, 0); push_tr(1, 1, 0); push_tr(2, 1, 0); push_tr(3, 1, 0);
    push_tr(4, 1, 0);
    pulse_start(2, 9, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_cnt_rst", int'(cnt_rst), 1);
    chk("midrst_cnt_up_down", int'(cnt_up_down), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_sweeps", int'(sweeps_done), 0);
    chk("midrst_count", int'(count), 0);
    drain("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
